snake_tick_ctrl: RTL and testbench

- Game-pacing and input-sequencing controller for the snake core.
- Generates the periodic game step, buffers player turns in a 2-deep queue, rejects illegal reversals and presents a stable Next_Dir.
- Drives the core's Ack handshake for start and restart, and watches the core's one-hot state outputs to pause, stop and restart the game.
- Sits between the debounced button pulses and the snake core.

---
 rtl/snake_tick_ctrl.sv | 125 ++++++++++++
 tb/tb_snake_tick_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/snake_tick_ctrl.sv
// snake_tick_ctrl: game pacing, turn queueing and start/restart handshake for the snake core
// Ports:
//   Clk        rising-edge clock
//   Reset      synchronous active-low reset
//   BtnL/R/U/D debounced single-cycle button pulses
//   Start      start/restart pulse, Pause pause-toggle pulse
//   Qw, Ql     core WIN / LOSE flags, Length current snake length
//   Next_Dir   direction to the core (00 L, 01 R, 10 U, 11 D)
//   Ack        one-cycle acknowledge to the core
//   Step       one-cycle game-step pulse, Running high while running
//   Queue_Cnt  number of buffered turns (0..2)
module snake_tick_ctrl #(
  parameter logic [15:0] TICK_DIV   = 16'd50000,
  parameter logic [15:0] SPEED_STEP = 16'd2000,
  parameter logic [15:0] MIN_PERIOD = 16'd10000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Qw,
  input  logic       Ql,
  input  logic [3:0] Length,
  output logic [1:0] Next_Dir,
  output logic       Ack,
  output logic       Step,
  output logic       Running,
  output logic [1:0] Queue_Cnt
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  localparam logic [1:0] DIR_R = 2'b01;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  dir_q, dir_d, q0_q, q0_d, q1_q, q1_d, qcnt_q, qcnt_d;
  logic        ack_q, ack_d, step_q, step_d, run_q, run_d;
  logic [19:0] dec;
  logic [15:0] diff, reload;
  logic [1:0]  btn_dir, ref_dir, c1;
  logic        btn_v, accept, tick, pop, push;
  // Period shrinks with length; a borrow out of 16 bits or a too-short result clamps to the floor.
  always_comb begin
    dec     = {4'd0, SPEED_STEP} * {16'd0, Length};
    diff    = TICK_DIV - dec[15:0];
    reload  = ((dec > {4'd0, TICK_DIV}) || (diff < MIN_PERIOD) ? MIN_PERIOD : diff) - 16'd1;
    btn_v   = BtnL | BtnR | BtnU | BtnD;
    btn_dir = BtnL ? 2'b00 : BtnR ? 2'b01 : BtnU ? 2'b10 : 2'b11;
    // A turn is judged against the newest buffered turn, before any pop this cycle.
    ref_dir = qcnt_q == 2'd0 ? dir_q : qcnt_q == 2'd1 ? q0_q : q1_q;
    // Opposite directions differ only in bit 0 (L/R, U/D).
    accept  = btn_v && btn_dir != ref_dir && btn_dir != {ref_dir[1], ~ref_dir[0]};
    tick    = cnt_q == 16'd0;
    pop     = tick && qcnt_q != 2'd0;
    // A full queue can still take a turn when its head leaves in the same cycle.
    push    = accept && (qcnt_q < 2'd2 || pop);
    c1      = qcnt_q - {1'b0, pop};
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    qcnt_d  = qcnt_q;
    ack_d   = 1'b0;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: if (Start) begin
        ack_d   = 1'b1;
        dir_d   = DIR_R;
        qcnt_d  = 2'd0;
        cnt_d   = reload;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (Qw || Ql) state_d = S_DONE;
        else if (Pause) state_d = S_PAUSE;
        else begin
          step_d = tick;
          cnt_d  = tick ? reload : cnt_q - 16'd1;
          dir_d  = pop ? q0_q : dir_q;
          q0_d   = push && c1 == 2'd0 ? btn_dir : pop ? q1_q : q0_q;
          q1_d   = push && c1 == 2'd1 ? btn_dir : q1_q;
          qcnt_d = c1 + {1'b0, push};
        end
      end
      S_PAUSE: state_d = Qw || Ql ? S_DONE : Pause ? S_RUN : S_PAUSE;
      default: if (Start) begin
        ack_d   = 1'b1;
        qcnt_d  = 2'd0;
        state_d = S_IDLE;
      end
    endcase
    run_d = state_d == S_RUN;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      dir_q   <= DIR_R;
      q0_q    <= 2'b00;
      q1_q    <= 2'b00;
      qcnt_q  <= 2'd0;
      ack_q   <= 1'b0;
      step_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      qcnt_q  <= qcnt_d;
      ack_q   <= ack_d;
      step_q  <= step_d;
      run_q   <= run_d;
    end
  end
  assign Next_Dir  = dir_q;
  assign Ack       = ack_q;
  assign Step      = step_q;
  assign Running   = run_q;
  assign Queue_Cnt = qcnt_q;
endmodule

// File: tb/tb_snake_tick_ctrl.sv
// tb_snake_tick_ctrl: directed bench with a step scoreboard for snake_tick_ctrl
module tb_snake_tick_ctrl;
  logic       Clk = 1'b0, Reset = 1'b0;
  logic       BtnL = 1'b0, BtnR = 1'b0, BtnU = 1'b0, BtnD = 1'b0;
  logic       Start = 1'b0, Pause = 1'b0, Qw = 1'b0, Ql = 1'b0;
  logic [3:0] Length = 4'd0;
  logic [1:0] Next_Dir, Queue_Cnt;
  logic       Ack, Step, Running;
  int nv = 0, nerr = 0, cyc = 0, s = 0, g = 0;
  typedef struct {int c; logic [1:0] d;} ev_t;
  ev_t sb[$];
  snake_tick_ctrl #(.TICK_DIV(16'd8), .SPEED_STEP(16'd1), .MIN_PERIOD(16'd4)) dut (
    .Clk(Clk), .Reset(Reset), .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD),
    .Start(Start), .Pause(Pause), .Qw(Qw), .Ql(Ql), .Length(Length),
    .Next_Dir(Next_Dir), .Ack(Ack), .Step(Step), .Running(Running), .Queue_Cnt(Queue_Cnt)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nv++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic push_step(input int c, input logic [1:0] d);
    sb.push_back('{c: c, d: d});
  endtask
  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0 && sb[0].c == cyc) begin
      check("step", 16'(Step), 16'd1);
      check("step_dir", 16'(Next_Dir), 16'(sb[0].d));
      void'(sb.pop_front());
    end else check("no_step", 16'(Step), 16'd0);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge Clk);
  endtask
  task automatic press(input logic [3:0] b);
    {BtnL, BtnR, BtnU, BtnD} = b;
    @(negedge Clk);
    {BtnL, BtnR, BtnU, BtnD} = 4'b0000;
  endtask
  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask
  task automatic pulse_pause();
    Pause = 1'b1;
    @(negedge Clk);
    Pause = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    check({tag, "_dir"}, 16'(Next_Dir), 16'd1);
    check({tag, "_ack"}, 16'(Ack), 16'd0);
    check({tag, "_step"}, 16'(Step), 16'd0);
    check({tag, "_run"}, 16'(Running), 16'd0);
    check({tag, "_qcnt"}, 16'(Queue_Cnt), 16'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(3);
    chk_reset("rst");
    Reset = 1'b1;
    tick(2);
    check("idle_run", 16'(Running), 16'd0);
    pulse_start();
    s = cyc;
    check("start_ack", 16'(Ack), 16'd1);
    check("start_run", 16'(Running), 16'd1);
    check("start_dir", 16'(Next_Dir), 16'd1);
    push_step(s + 8, 2'b01);
    push_step(s + 16, 2'b01);
    tick(1);
    check("ack_once", 16'(Ack), 16'd0);
    wait_until(s + 16);
    press(4'b0010);
    press(4'b1000);
    check("q_two", 16'(Queue_Cnt), 16'd2);
    press(4'b0001);
    check("q_full_drop", 16'(Queue_Cnt), 16'd2);
    push_step(s + 24, 2'b10);
    push_step(s + 32, 2'b00);
    wait_until(s + 24);
    check("pop1_q", 16'(Queue_Cnt), 16'd1);
    wait_until(s + 32);
    check("pop2_q", 16'(Queue_Cnt), 16'd0);
    press(4'b0110);
    check("prio_r_rev", 16'(Queue_Cnt), 16'd0);
    Length = 4'd3;
    push_step(s + 40, 2'b00);
    push_step(s + 45, 2'b00);
    push_step(s + 50, 2'b00);
    push_step(s + 54, 2'b00);
    push_step(s + 58, 2'b00);
    push_step(s + 62, 2'b00);
    wait_until(s + 45);
    Length = 4'd6;
    wait_until(s + 50);
    Length = 4'd15;
    wait_until(s + 58);
    Length = 4'd0;
    wait_until(s + 62);
    tick(3);
    pulse_pause();
    check("pause_run", 16'(Running), 16'd0);
    tick(20);
    press(4'b0010);
    check("pause_btn", 16'(Queue_Cnt), 16'd0);
    pulse_start();
    check("pause_start_ack", 16'(Ack), 16'd0);
    pulse_pause();
    check("resume_run", 16'(Running), 16'd1);
    push_step(cyc + 5, 2'b00);
    pulse_start();
    check("run_start_ack", 16'(Ack), 16'd0);
    check("run_start_run", 16'(Running), 16'd1);
    wait_until(s + 101);
    Ql = 1'b1;
    @(negedge Clk);
    Ql = 1'b0;
    check("done_run", 16'(Running), 16'd0);
    press(4'b1000);
    check("done_btn", 16'(Queue_Cnt), 16'd0);
    pulse_pause();
    check("done_pause", 16'(Running), 16'd0);
    pulse_start();
    check("restart_ack", 16'(Ack), 16'd1);
    check("restart_run", 16'(Running), 16'd0);
    tick(1);
    check("restart_ack_once", 16'(Ack), 16'd0);
    tick(10);
    check("idle2_run", 16'(Running), 16'd0);
    check("idle2_dir", 16'(Next_Dir), 16'd0);
    pulse_start();
    g = cyc;
    check("g2_ack", 16'(Ack), 16'd1);
    check("g2_dir", 16'(Next_Dir), 16'd1);
    press(4'b1000);
    check("rev_drop", 16'(Queue_Cnt), 16'd0);
    press(4'b0010);
    check("u_queued", 16'(Queue_Cnt), 16'd1);
    press(4'b0001);
    check("d_rev_tail", 16'(Queue_Cnt), 16'd1);
    push_step(g + 8, 2'b10);
    wait_until(g + 8);
    check("g2_pop_q", 16'(Queue_Cnt), 16'd0);
    push_step(g + 16, 2'b10);
    push_step(g + 24, 2'b00);
    wait_until(g + 15);
    press(4'b1000);
    check("empty_popush_q", 16'(Queue_Cnt), 16'd1);
    check("empty_popush_dir", 16'(Next_Dir), 16'd2);
    wait_until(g + 24);
    check("g2_pop2_q", 16'(Queue_Cnt), 16'd0);
    press(4'b0010);
    press(4'b0100);
    check("g2_full", 16'(Queue_Cnt), 16'd2);
    push_step(g + 32, 2'b10);
    push_step(g + 40, 2'b01);
    push_step(g + 48, 2'b11);
    wait_until(g + 31);
    press(4'b0001);
    check("full_popush_q", 16'(Queue_Cnt), 16'd2);
    wait_until(g + 40);
    check("full_popush_q2", 16'(Queue_Cnt), 16'd1);
    wait_until(g + 44);
    sb.delete();
    Reset = 1'b0;
    @(negedge Clk);
    chk_reset("mid_rst");
    Reset = 1'b1;
    tick(12);
    check("post_rst_run", 16'(Running), 16'd0);
    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
